weight_load_scheduler: RTL
==========================

Name: weight_load_scheduler

Overview:
- Sequences the weight/bias buffer for one convolution task.
- Accepts a per-task configuration and serves weight-set requests from the PE array. For each request it issues a single-cycle change_weight_bias command, waits for the buffer to finish, and acknowledges the PE array.
- Counts delivered beats to check integrity.
- After the last group, or on abort, it pulses task_finish, which also flushes the buffer FIFO.

Parameters:
- GROUP_W, 16: width of the group count and group index.
- WEIGHT_BEATS, 72: weight beats per group (8 PE lanes x 9 reads).
- BIAS_BEATS, 1: bias beats per group.
- BEAT_CNT_W, 8: width of the beat counter; must hold WEIGHT_BEATS+BIAS_BEATS.

Ports:
- system_clk  in  1  clock; single clock domain.
- rst  in  1  synchronous reset, active-high.
- cfg_valid  in  1  task configuration valid.
- cfg_ready  out  1  high only in IDLE.
- cfg_group_num  in  GROUP_W  number of weight groups in the task.
- cfg_bias_en  in  1  1: load weight+bias per group (code 11); 0: weight only (code 01).
- abort  in  1  cancels the task at any state.
- pe_weight_req  in  1  level request from the PE array for the next weight set.
- pe_weight_ack  out  1  1-cycle pulse: the current group is fully delivered.
- group_idx  out  GROUP_W  index of the group being or last loaded.
- change_weight_bias  out  2  command to the weight buffer; nonzero for exactly one cycle per group.
- weight_and_bias_ready  in  1  buffer idle with no pending command.
- weight_bias_output_valid  in  9  buffer one-hot beat strobe.
- task_finish  out  1  1-cycle pulse at task end or abort.
- busy  out  1  high in every state except IDLE.
- beat_err  out  1  sticky beat-count mismatch flag; cleared by rst or cfg acceptance.

Behaviour:
Reset:
- Every output is 0 except cfg_ready, which is 1.
- State goes to IDLE; counters clear.
- rst mid-task drops everything at once; no task_finish pulse is generated.

States:
- IDLE:
  - cfg_valid&cfg_ready latches group_num and bias_en, clears group_idx and beat_err, then goes to ARMED.
  - If cfg_group_num==0 it goes to FINISH instead.
- ARMED:
  - pe_weight_req sampled high moves to ISSUE next cycle.
  - pe_weight_req is sampled only in ARMED.
- ISSUE (one cycle):
  - change_weight_bias = bias_en ? 2'b11 : 2'b01.
  - Beat counter clears.
  - Next state is WAIT.
- WAIT:
  - change_weight_bias = 00.
  - The beat counter increments on every cycle with |weight_bias_output_valid.
  - Completion is weight_and_bias_ready==1. The buffer's final strobe can coincide with the ready cycle, so the comparison includes that cycle's beat.
  - Expected total is WEIGHT_BEATS+(bias_en?BIAS_BEATS:0); a mismatch sets beat_err.
  - On completion go to ACK.
- ACK (one cycle):
  - pe_weight_ack=1.
  - If group_idx==group_num-1, go to FINISH; otherwise group_idx+1 and go to ARMED.
- FINISH (one cycle):
  - task_finish=1, then go to IDLE.

Handshake and timing:
- ready is never sampled in the ISSUE cycle. The buffer deasserts it the following cycle, and WAIT begins at that point.
- Latency from req sampled in ARMED to the command is 1 cycle.
- A PE that holds req high through the ack gets back-to-back groups: ACK, ARMED, ISSUE, 3 cycles minimum per group plus buffer time.

Abort:
- Highest priority in every state except IDLE; next state is FINISH.
- If abort arrives in ISSUE, the command still issues; FINISH's task_finish flushes the buffer.
- In IDLE, abort is ignored.
- If cfg_valid and abort arrive together in IDLE, cfg is accepted.

Width and overflow:
- The beat counter saturates at all-ones; saturation implies a mismatch.
- group_idx never wraps within a task.

Test Plan:
1. cfg_group_num=3, bias_en=0, req held high, buffer model supplies 72 beats/group -> exactly three change=01 single-cycle pulses, ack pulses with group_idx 0,1,2, then one task_finish, beat_err=0, cfg_ready=1.
2. cfg_group_num=2, bias_en=1, last beat coincident with ready -> change=11 twice, 73 beats counted per group, beat_err=0.
3. Model delivers 71 beats in group 1 of 2 -> beat_err=1 after second ack, stays 1 through task_finish, clears on next cfg acceptance.
4. cfg_group_num=0 -> FINISH next cycle, task_finish pulse, no change command, no ack.
5. abort asserted in WAIT of group 1 of 4 -> no ack, task_finish next cycle, IDLE after; abort during ISSUE -> command seen once, then task_finish.
6. rst asserted in WAIT -> next cycle all outputs 0, cfg_ready=1, no task_finish; a new cfg then runs normally from group_idx 0.

Source files
------------

// File: rtl/weight_load_scheduler.sv
// Weight/bias buffer sequencer: one change_weight_bias command per PE request,
// counts the buffer's beats, acknowledges the PE array, then pulses task_finish.
module weight_load_scheduler #(
  parameter int GROUP_W      = 16,
  parameter int WEIGHT_BEATS = 72,
  parameter int BIAS_BEATS   = 1,
  parameter int BEAT_CNT_W   = 8
) (
  input  logic               system_clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [GROUP_W-1:0] cfg_group_num,
  input  logic               cfg_bias_en,
  input  logic               abort,
  input  logic               pe_weight_req,
  output logic               pe_weight_ack,
  output logic [GROUP_W-1:0] group_idx,
  output logic [1:0]         change_weight_bias,
  input  logic               weight_and_bias_ready,
  input  logic [8:0]         weight_bias_output_valid,
  output logic               task_finish,
  output logic               busy,
  output logic               beat_err,
  output logic [2:0]         dbg_state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ARMED  = 3'd1;
  localparam logic [2:0] S_ISSUE  = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_ACK    = 3'd4;
  localparam logic [2:0] S_FINISH = 3'd5;

  localparam logic [GROUP_W-1:0]    LP_GRP_ONE  = GROUP_W'(1);
  localparam logic [BEAT_CNT_W-1:0] LP_BEAT_ONE = BEAT_CNT_W'(1);
  localparam logic [BEAT_CNT_W:0]   LP_EXP_W    = (BEAT_CNT_W+1)'(WEIGHT_BEATS);
  localparam logic [BEAT_CNT_W:0]   LP_EXP_WB   = (BEAT_CNT_W+1)'(WEIGHT_BEATS + BIAS_BEATS);

  logic [2:0]            r_state;
  logic [2:0]            w_next;
  logic [GROUP_W-1:0]    r_group_num;
  logic                  r_bias_en;
  logic [GROUP_W-1:0]    r_group_idx;
  logic [BEAT_CNT_W-1:0] r_beat_cnt;
  logic                  r_beat_err;
  logic                  w_beat;
  logic                  w_last;
  logic                  w_wait_done;
  logic                  w_mismatch;
  logic [BEAT_CNT_W:0]   w_beat_total;
  logic [BEAT_CNT_W:0]   w_beat_exp;

  // Handshakes: cfg is taken on an edge where cfg_valid & cfg_ready (IDLE only);
  // pe_weight_req is a level sampled only in ARMED; weight_and_bias_ready is
  // sampled only in WAIT, since the buffer drops it the cycle after the command.
  assign w_beat       = |weight_bias_output_valid;
  assign w_last       = (r_group_idx == (r_group_num - LP_GRP_ONE));
  assign w_wait_done  = (r_state == S_WAIT) && weight_and_bias_ready && !abort;
  assign w_beat_total = {1'b0, r_beat_cnt} + {{BEAT_CNT_W{1'b0}}, w_beat};
  assign w_beat_exp   = r_bias_en ? LP_EXP_WB : LP_EXP_W;
  // A saturated counter can no longer be trusted, so it always flags an error.
  assign w_mismatch   = (r_beat_cnt == '1) || (w_beat_total != w_beat_exp);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (cfg_valid) w_next = (cfg_group_num == '0) ? S_FINISH : S_ARMED;
      S_ARMED:  if (pe_weight_req) w_next = S_ISSUE;
      S_ISSUE:  w_next = S_WAIT;
      S_WAIT:   if (weight_and_bias_ready) w_next = S_ACK;
      S_ACK:    w_next = w_last ? S_FINISH : S_ARMED;
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
    // FINISH is already the abort target, so it is left to complete normally.
    if (abort && (r_state != S_IDLE) && (r_state != S_FINISH)) w_next = S_FINISH;
  end

  always_ff @(posedge system_clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_group_num <= '0;
      r_bias_en   <= 1'b0;
      r_group_idx <= '0;
      r_beat_cnt  <= '0;
      r_beat_err  <= 1'b0;
    end else begin
      r_state <= w_next;
      if ((r_state == S_IDLE) && cfg_valid) begin
        r_group_num <= cfg_group_num;
        r_bias_en   <= cfg_bias_en;
        r_group_idx <= '0;
        r_beat_err  <= 1'b0;
      end
      if (r_state == S_ISSUE) begin
        r_beat_cnt <= '0;
      end else if ((r_state == S_WAIT) && w_beat && (r_beat_cnt != '1)) begin
        r_beat_cnt <= r_beat_cnt + LP_BEAT_ONE;
      end
      if (w_wait_done && w_mismatch) r_beat_err <= 1'b1;
      if ((r_state == S_ACK) && !abort && !w_last) r_group_idx <= r_group_idx + LP_GRP_ONE;
    end
  end

  assign cfg_ready          = (r_state == S_IDLE);
  assign busy               = (r_state != S_IDLE);
  assign pe_weight_ack      = (r_state == S_ACK);
  assign task_finish        = (r_state == S_FINISH);
  assign change_weight_bias = (r_state == S_ISSUE) ? (r_bias_en ? 2'b11 : 2'b01) : 2'b00;
  assign group_idx          = r_group_idx;
  assign beat_err           = r_beat_err;
  assign dbg_state          = r_state;

endmodule
